// File: rtl/iq_capture_bram.sv
// Packs the dot11_tx I/Q sample stream two samples per 64-bit word into a capture BRAM port.
// Optional macro IQ_CAPTURE_WRAP_EN: when the buffer fills, wrap and keep overwriting until frame_end.
module iq_capture_bram #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic              frame_end,
  input  logic              iq_valid,
  output logic              iq_ready,
  input  logic [15:0]       iq_i,
  input  logic [15:0]       iq_q,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [63:0]       bram_dout,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W+1:0] sample_count,
  output logic [ADDR_W:0]   word_count
);

`ifdef IQ_CAPTURE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W+1:0] SC_ONE  = {{(ADDR_W+1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WC_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_r;
  logic                pending_r;
  logic [31:0]         low_r;
  logic [ADDR_W-1:0]   ptr_r;
  logic                iq_ready_r;
  logic                bram_we_r;
  logic [ADDR_W-1:0]   bram_addr_r;
  logic [63:0]         bram_dout_r;
  logic                busy_r;
  logic                done_r;
  logic                overflow_r;
  logic [ADDR_W+1:0]   sample_count_r;
  logic [ADDR_W:0]     word_count_r;

  logic take_s;
  logic capturing_s;
  logic full_write_s;

  function automatic logic [ADDR_W+1:0] sat_inc_samples(input logic [ADDR_W+1:0] v);
    return (&v) ? v : v + SC_ONE;
  endfunction

  function automatic logic [ADDR_W:0] sat_inc_words(input logic [ADDR_W:0] v);
    return (&v) ? v : v + WC_ONE;
  endfunction

  assign take_s       = iq_valid && iq_ready_r;
  assign capturing_s  = (state_r == S_ARMED) || (state_r == S_CAPTURE);
  // An odd sample completes a word; writing the last address means the buffer is full.
  assign full_write_s = capturing_s && take_s && pending_r && (ptr_r == PTR_MAX);

  // Capture FSM, sample packing, BRAM write port and status counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= S_IDLE;
      pending_r      <= 1'b0;
      low_r          <= 32'h0;
      ptr_r          <= {ADDR_W{1'b0}};
      iq_ready_r     <= 1'b1;
      bram_we_r      <= 1'b0;
      bram_addr_r    <= {ADDR_W{1'b0}};
      bram_dout_r    <= 64'h0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      overflow_r     <= 1'b0;
      sample_count_r <= {(ADDR_W+2){1'b0}};
      word_count_r   <= {(ADDR_W+1){1'b0}};
    end else begin
      bram_we_r <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_r        <= S_ARMED;
            pending_r      <= 1'b0;
            ptr_r          <= {ADDR_W{1'b0}};
            busy_r         <= 1'b1;
            done_r         <= 1'b0;
            overflow_r     <= 1'b0;
            sample_count_r <= {(ADDR_W+2){1'b0}};
            word_count_r   <= {(ADDR_W+1){1'b0}};
          end else begin
            state_r <= state_r;
          end
        end
        S_ARMED, S_CAPTURE: begin
          if (take_s) begin
            sample_count_r <= sat_inc_samples(sample_count_r);
            if (!pending_r) begin
              low_r     <= {iq_q, iq_i};
              pending_r <= 1'b1;
            end else begin
              pending_r    <= 1'b0;
              bram_we_r    <= 1'b1;
              bram_addr_r  <= ptr_r;
              bram_dout_r  <= {iq_q, iq_i, low_r};
              ptr_r        <= ptr_r + PTR_ONE;
              word_count_r <= sat_inc_words(word_count_r);
              if (ptr_r == PTR_MAX) begin
                overflow_r <= 1'b1;
              end else begin
                overflow_r <= overflow_r;
              end
            end
          end else begin
            pending_r <= pending_r;
          end
          // The sample of this cycle is already accounted for, so frame_end sees the updated pending flag.
          if ((full_write_s && !WRAP_EN) || (frame_end && !(pending_r ^ take_s))) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (frame_end) begin
            state_r    <= S_FLUSH;
            iq_ready_r <= 1'b0;
          end else if (take_s) begin
            state_r <= S_CAPTURE;
          end else begin
            state_r <= state_r;
          end
        end
        S_FLUSH: begin
          pending_r    <= 1'b0;
          bram_we_r    <= 1'b1;
          bram_addr_r  <= ptr_r;
          bram_dout_r  <= {32'h0, low_r};
          ptr_r        <= ptr_r + PTR_ONE;
          word_count_r <= sat_inc_words(word_count_r);
          overflow_r   <= overflow_r | (ptr_r == PTR_MAX);
          iq_ready_r   <= 1'b1;
          state_r      <= S_DONE;
          busy_r       <= 1'b0;
          done_r       <= 1'b1;
        end
        default: begin
          state_r    <= S_IDLE;
          pending_r  <= 1'b0;
          iq_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign iq_ready     = iq_ready_r;
  assign bram_we      = bram_we_r;
  assign bram_addr    = bram_addr_r;
  assign bram_dout    = bram_dout_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign overflow     = overflow_r;
  assign sample_count = sample_count_r;
  assign word_count   = word_count_r;

endmodule

// File: tb/tb_iq_capture_bram.sv
// Directed bench for iq_capture_bram with a small capture depth (8 words); expected BRAM writes
// are queued as samples are driven and checked when bram_we fires. Honors IQ_CAPTURE_WRAP_EN.
module tb_iq_capture_bram;
  localparam int AW = 3;

`ifdef IQ_CAPTURE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, arm, frame_end, iq_valid;
  logic          iq_ready, bram_we, busy, done, overflow;
  logic [15:0]   iq_i, iq_q;
  logic [AW-1:0] bram_addr;
  logic [63:0]   bram_dout;
  logic [AW+1:0] sample_count;
  logic [AW:0]   word_count;

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;
  wr_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int ready_low = 0;
  int rl0;

  iq_capture_bram #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .arm(arm), .frame_end(frame_end),
    .iq_valid(iq_valid), .iq_ready(iq_ready), .iq_i(iq_i), .iq_q(iq_q),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .busy(busy), .done(done), .overflow(overflow),
    .sample_count(sample_count), .word_count(word_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!iq_ready) ready_low++;
    if (bram_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {61'h0, bram_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", {61'h0, bram_addr}, {61'h0, e.addr});
        chk("wr_data", bram_dout, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] i, input logic [15:0] q, input logic fe);
    iq_valid = 1'b1; iq_i = i; iq_q = q; frame_end = fe;
    tick();
    iq_valid = 1'b0; frame_end = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [63:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"}, {63'h0, bram_we}, 64'h0);
    chk({tag, "_addr"}, {61'h0, bram_addr}, 64'h0);
    chk({tag, "_dout"}, bram_dout, 64'h0);
    chk({tag, "_flags"}, {61'h0, busy, done, overflow}, 64'h0);
    chk({tag, "_cnts"}, {55'h0, sample_count, word_count}, 64'h0);
    chk({tag, "_ready"}, {63'h0, iq_ready}, 64'h1);
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; frame_end = 1'b0; iq_valid = 1'b0;
    iq_i = 16'h0; iq_q = 16'h0;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Samples while IDLE are dropped.
    send(16'h7777, 16'h8888, 1'b0);
    send(16'h7777, 16'h8888, 1'b0);
    tick();
    chk("idle_drop_cnt", {55'h0, sample_count, word_count}, 64'h0);

    // 1: four samples, then frame_end: two full words, no flush.
    pulse_arm();
    chk("t1_busy", {62'h0, busy, done}, 64'h2);
    push(3'd0, 64'h0004_0003_0002_0001);
    push(3'd1, 64'h0008_0007_0006_0005);
    rl0 = ready_low;
    send(16'd1, 16'd2, 1'b0);
    send(16'd3, 16'd4, 1'b0);
    send(16'd5, 16'd6, 1'b0);
    send(16'd7, 16'd8, 1'b0);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    chk("t1_done", {61'h0, busy, done, overflow}, 64'h2);
    chk("t1_samples", {59'h0, sample_count}, 64'd4);
    chk("t1_words", {60'h0, word_count}, 64'd2);
    tick();
    chk("t1_no_flush", ready_low - rl0, 64'd0);

    // 2: three samples then frame_end: one flush word, ready low for one cycle.
    pulse_arm();
    push(3'd0, 64'h0014_0013_0012_0011);
    push(3'd1, 64'h0000_0000_0016_0015);
    rl0 = ready_low;
    send(16'h11, 16'h12, 1'b0);
    send(16'h13, 16'h14, 1'b0);
    send(16'h15, 16'h16, 1'b0);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    chk("t2_flush_ready", {62'h0, iq_ready, busy}, 64'h1);
    tick();
    chk("t2_done", {62'h0, busy, done}, 64'h1);
    chk("t2_cnts", {55'h0, sample_count, word_count}, {55'h0, 5'd3, 4'd2});
    tick();
    chk("t2_ready_low_cycles", ready_low - rl0, 64'd1);

    // 5: frame_end coincident with the odd sample.
    pulse_arm();
    push(3'd0, 64'h0024_0023_0022_0021);
    rl0 = ready_low;
    send(16'h21, 16'h22, 1'b0);
    send(16'h23, 16'h24, 1'b1);
    chk("t5_done", {62'h0, busy, done}, 64'h1);
    chk("t5_cnts", {55'h0, sample_count, word_count}, {55'h0, 5'd2, 4'd1});
    tick();
    chk("t5_no_flush", ready_low - rl0, 64'd0);

    // 3/4: twenty samples into an eight-word buffer.
    pulse_arm();
    for (int w = 0; w < (WRAP ? 10 : 8); w++)
      push(w[AW-1:0], {16'(2*w+102), 16'(2*w+2), 16'(2*w+101), 16'(2*w+1)});
    rl0 = ready_low;
    for (int k = 1; k <= 20; k++) begin
      send(16'(k), 16'(k+100), 1'b0);
      if (k == 15) chk("full_not_yet", {62'h0, done, overflow}, 64'h0);
      if (k == 16) begin
        tick();
        chk("full_state", {61'h0, busy, done, overflow}, WRAP ? 64'h5 : 64'h3);
      end
    end
    tick();
    chk("full_ready_high", ready_low - rl0, 64'd0);
    chk("full_cnts_pre_fe", {55'h0, sample_count, word_count},
        WRAP ? {55'h0, 5'd20, 4'd10} : {55'h0, 5'd16, 4'd8});
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    chk("full_end", {61'h0, busy, done, overflow}, 64'h3);
    tick();

    // 6: reset with a half word pending: only the completed word is written.
    pulse_arm();
    push(3'd0, 64'h0034_0033_0032_0031);
    send(16'h31, 16'h32, 1'b0);
    send(16'h33, 16'h34, 1'b0);
    send(16'h35, 16'h36, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals("midreset");
    reset = 1'b0;
    repeat (3) tick();
    chk("sb_empty", sb.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
